// File: rtl/ex_alu_mdu_if.sv
// EX stage bundle: ID/EX inputs, EX/MEM outputs, stall and HI/LO visibility.
interface ex_alu_mdu_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              ex_valid_i;
  logic [7:0]        ex_aluop_i;
  logic [2:0]        ex_alusel_i;
  logic [DATA_W-1:0] ex_rdata_1_i;
  logic [DATA_W-1:0] ex_rdata_2_i;
  logic [REG_AW-1:0] ex_waddr_i;
  logic              ex_we_i;
  logic              ex_flush_i;
  logic              ex_stall_o;
  logic              ex_valid_o;
  logic [DATA_W-1:0] ex_wdata_o;
  logic [REG_AW-1:0] ex_waddr_o;
  logic              ex_we_o;
  logic [DATA_W-1:0] ex_hi_o;
  logic [DATA_W-1:0] ex_lo_o;

  // Upstream pipeline side: drives the instruction, observes results
  modport master (
    output ex_valid_i, ex_aluop_i, ex_alusel_i, ex_rdata_1_i, ex_rdata_2_i,
           ex_waddr_i, ex_we_i, ex_flush_i,
    input  ex_stall_o, ex_valid_o, ex_wdata_o, ex_waddr_o, ex_we_o,
           ex_hi_o, ex_lo_o
  );

  // EX stage side
  modport slave (
    input  ex_valid_i, ex_aluop_i, ex_alusel_i, ex_rdata_1_i, ex_rdata_2_i,
           ex_waddr_i, ex_we_i, ex_flush_i,
    output ex_stall_o, ex_valid_o, ex_wdata_o, ex_waddr_o, ex_we_o,
           ex_hi_o, ex_lo_o
  );
endinterface

// File: rtl/ex_alu_mdu.sv
// Simple-MIPS EX stage: single-cycle ALU plus iterative unsigned MULTU/DIVU
// with HI/LO, registered into the EX/MEM boundary.
module ex_alu_mdu #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic         clk,
  input  logic         rst,
  ex_alu_mdu_if.slave  bus
);
  localparam int SH_W = $clog2(DATA_W);

  localparam logic [7:0] OP_OR   = 8'h25, OP_AND  = 8'h24, OP_XOR  = 8'h26,
                         OP_NOR  = 8'h27, OP_SLL  = 8'h7C, OP_SRL  = 8'h02,
                         OP_SRA  = 8'h03, OP_ADDU = 8'h21, OP_SUBU = 8'h23,
                         OP_SLT  = 8'h2A, OP_SLTU = 8'h2B, OP_MFHI = 8'h10,
                         OP_MFLO = 8'h12, OP_MULTU = 8'h19, OP_DIVU = 8'h1B;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state;
  logic [SH_W-1:0]     cnt;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   opnd;
  logic                is_div;
  logic [DATA_W-1:0]   hi, lo, wdata;
  logic [REG_AW-1:0]   waddr;
  logic                valid, we;

  logic [DATA_W-1:0]   a, b, alu_res;
  logic [SH_W-1:0]     shamt;
  logic                stall, accept, is_mdu;
  logic [DATA_W:0]     mul_sum, div_shift, div_diff;
  logic [2*DATA_W-1:0] mul_next, div_next;

  assign a      = bus.ex_rdata_1_i;
  assign b      = bus.ex_rdata_2_i;
  assign shamt  = a[SH_W-1:0];
  assign stall  = (state != IDLE);
  assign accept = bus.ex_valid_i & ~stall & ~bus.ex_flush_i;
  assign is_mdu = (bus.ex_alusel_i == 3'b101) &&
                  ((bus.ex_aluop_i == OP_MULTU) || (bus.ex_aluop_i == OP_DIVU));

  // Single-cycle result; unknown op or class mismatch yields zero
  always_comb begin
    alu_res = '0;
    unique case (bus.ex_alusel_i)
      3'b001: case (bus.ex_aluop_i)
        OP_OR:   alu_res = a | b;
        OP_AND:  alu_res = a & b;
        OP_XOR:  alu_res = a ^ b;
        OP_NOR:  alu_res = ~(a | b);
        default: alu_res = '0;
      endcase
      3'b010: case (bus.ex_aluop_i)
        OP_SLL:  alu_res = b << shamt;
        OP_SRL:  alu_res = b >> shamt;
        OP_SRA:  alu_res = DATA_W'($signed(b) >>> shamt);
        default: alu_res = '0;
      endcase
      3'b011: case (bus.ex_aluop_i)
        OP_ADDU: alu_res = a + b;
        OP_SUBU: alu_res = a - b;
        OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
        OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (a < b)};
        default: alu_res = '0;
      endcase
      3'b100: case (bus.ex_aluop_i)
        OP_MFHI: alu_res = hi;
        OP_MFLO: alu_res = lo;
        default: alu_res = '0;
      endcase
      default: alu_res = '0;
    endcase
  end

  // One MDU step: shift-add multiply (acc = {partial, multiplier}) or
  // restoring divide (acc = {remainder, dividend/quotient})
  always_comb begin
    mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next  = {mul_sum, acc[DATA_W-1:1]};
    div_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_next  = {(div_diff[DATA_W] ? div_shift[DATA_W-1:0] : div_diff[DATA_W-1:0]),
                 acc[DATA_W-2:0], ~div_diff[DATA_W]};
  end

  // EX/MEM registers, HI/LO and MDU sequencing; flush wins over everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      wdata  <= '0;
      waddr  <= '0;
      valid  <= 1'b0;
      we     <= 1'b0;
    end else begin
      valid <= 1'b0;
      we    <= 1'b0;
      if (bus.ex_flush_i) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: if (accept) begin
            if (is_mdu) begin
              is_div <= (bus.ex_aluop_i == OP_DIVU);
              cnt    <= '0;
              if (bus.ex_aluop_i == OP_DIVU) begin
                opnd <= b;
                if (b == '0) begin
                  acc   <= {a, {DATA_W{1'b1}}};
                  state <= DONE;
                end else begin
                  acc   <= {{DATA_W{1'b0}}, a};
                  state <= BUSY;
                end
              end else begin
                opnd  <= a;
                acc   <= {{DATA_W{1'b0}}, b};
                state <= BUSY;
              end
            end else begin
              valid <= 1'b1;
              wdata <= alu_res;
              waddr <= bus.ex_waddr_i;
              we    <= bus.ex_we_i;
            end
          end
          BUSY: begin
            acc <= is_div ? div_next : mul_next;
            cnt <= cnt + 1'b1;
            if (cnt == SH_W'(DATA_W-1)) state <= DONE;
          end
          DONE: begin
            hi    <= acc[2*DATA_W-1:DATA_W];
            lo    <= acc[DATA_W-1:0];
            valid <= 1'b1;
            wdata <= '0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.ex_stall_o = stall;
  assign bus.ex_valid_o = valid;
  assign bus.ex_wdata_o = wdata;
  assign bus.ex_waddr_o = waddr;
  assign bus.ex_we_o    = we;
  assign bus.ex_hi_o    = hi;
  assign bus.ex_lo_o    = lo;
endmodule

// File: tb/tb_ex_alu_mdu.sv
// Directed bench for ex_alu_mdu at DATA_W=32 with hand-computed expectations.
module tb_ex_alu_mdu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   n;

  ex_alu_mdu_if #(.DATA_W(32), .REG_AW(5)) bus ();

  ex_alu_mdu #(.DATA_W(32), .REG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Present one instruction at a negedge, let it be accepted, return at the next negedge
  task automatic applyStimulus(input logic [7:0] op, input logic [2:0] sel,
                               input logic [31:0] ra, input logic [31:0] rb,
                               input logic [4:0] wa, input logic wen);
    bus.ex_valid_i   = 1'b1;
    bus.ex_aluop_i   = op;
    bus.ex_alusel_i  = sel;
    bus.ex_rdata_1_i = ra;
    bus.ex_rdata_2_i = rb;
    bus.ex_waddr_i   = wa;
    bus.ex_we_i      = wen;
    @(posedge clk);
    @(negedge clk);
    bus.ex_valid_i   = 1'b0;
  endtask

  // Count negedges with stall high, bounded
  task automatic countStall(output int cycles);
    cycles = 0;
    while (bus.ex_stall_o && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    string       tag;
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    bus.ex_valid_i   = 1'b0;
    bus.ex_aluop_i   = 8'h00;
    bus.ex_alusel_i  = 3'b000;
    bus.ex_rdata_1_i = '0;
    bus.ex_rdata_2_i = '0;
    bus.ex_waddr_i   = '0;
    bus.ex_we_i      = 1'b0;
    bus.ex_flush_i   = 1'b0;

    vecs.push_back('{"xor",   8'h26, 3'b001, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0});
    vecs.push_back('{"nor",   8'h27, 3'b001, 32'h0000FFFF, 32'h00FF0000, 32'hFF000000});
    vecs.push_back('{"and",   8'h24, 3'b001, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0});
    vecs.push_back('{"sll",   8'h7C, 3'b010, 32'hFFFFFFE4, 32'h00000001, 32'h00000010});
    vecs.push_back('{"srl",   8'h02, 3'b010, 32'h00000008, 32'h80000000, 32'h00800000});
    vecs.push_back('{"sra",   8'h03, 3'b010, 32'h00000004, 32'h80000000, 32'hF8000000});
    vecs.push_back('{"selmis",8'h25, 3'b011, 32'h12345678, 32'h0000FFFF, 32'h00000000});
    vecs.push_back('{"addu",  8'h21, 3'b011, 32'hFFFFFFFF, 32'h00000002, 32'h00000001});
    vecs.push_back('{"unkop", 8'h55, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000});
    vecs.push_back('{"subu",  8'h23, 3'b011, 32'h00000000, 32'h00000001, 32'hFFFFFFFF});
    vecs.push_back('{"slt",   8'h2A, 3'b011, 32'hFFFFFFFF, 32'h00000001, 32'h00000001});
    vecs.push_back('{"sltu",  8'h2B, 3'b011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000});

    // Reset state
    #12;
    checkOutput("rst_stall", bus.ex_stall_o, 0);
    checkOutput("rst_valid", bus.ex_valid_o, 0);
    checkOutput("rst_wdata", bus.ex_wdata_o, 0);
    checkOutput("rst_we",    bus.ex_we_o, 0);
    checkOutput("rst_hi",    bus.ex_hi_o, 0);
    checkOutput("rst_lo",    bus.ex_lo_o, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // OR with one-cycle latency and pass-through of waddr/we
    applyStimulus(8'h25, 3'b001, 32'h0000F0F0, 32'h00FF0000, 5'd9, 1'b1);
    checkOutput("or_valid", bus.ex_valid_o, 1);
    checkOutput("or_wdata", bus.ex_wdata_o, 32'h00FFF0F0);
    checkOutput("or_waddr", bus.ex_waddr_o, 5'd9);
    checkOutput("or_we",    bus.ex_we_o, 1);
    @(negedge clk);
    checkOutput("or_valid_drop", bus.ex_valid_o, 0);
    checkOutput("or_wdata_hold", bus.ex_wdata_o, 32'h00FFF0F0);

    // Single-cycle vectors
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].sel, vecs[i].ra, vecs[i].rb, 5'(i + 1), 1'b1);
      checkOutput(vecs[i].tag, bus.ex_wdata_o, vecs[i].exp);
      checkOutput({vecs[i].tag, "_we"}, bus.ex_we_o, 1);
      checkOutput({vecs[i].tag, "_valid"}, bus.ex_valid_o, 1);
    end

    // MULTU with we requested: stall 33 cycles, then valid with we forced low
    applyStimulus(8'h19, 3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 1'b1);
    countStall(n);
    checkOutput("mul_stall", n, 33);
    checkOutput("mul_valid", bus.ex_valid_o, 1);
    checkOutput("mul_we",    bus.ex_we_o, 0);
    checkOutput("mul_wdata", bus.ex_wdata_o, 0);
    checkOutput("mul_hi",    bus.ex_hi_o, 32'hFFFFFFFE);
    checkOutput("mul_lo",    bus.ex_lo_o, 32'h00000001);
    applyStimulus(8'h10, 3'b100, 32'h0, 32'h0, 5'd4, 1'b1);
    checkOutput("mfhi", bus.ex_wdata_o, 32'hFFFFFFFE);
    applyStimulus(8'h12, 3'b100, 32'h0, 32'h0, 5'd5, 1'b1);
    checkOutput("mflo", bus.ex_wdata_o, 32'h00000001);

    // DIVU 100/7 and divide by zero
    applyStimulus(8'h1B, 3'b101, 32'd100, 32'd7, 5'd6, 1'b1);
    countStall(n);
    checkOutput("div_stall", n, 33);
    checkOutput("div_valid", bus.ex_valid_o, 1);
    checkOutput("div_hi",    bus.ex_hi_o, 32'd2);
    checkOutput("div_lo",    bus.ex_lo_o, 32'd14);
    applyStimulus(8'h1B, 3'b101, 32'd5, 32'd0, 5'd6, 1'b0);
    countStall(n);
    checkOutput("dz_stall", n, 1);
    checkOutput("dz_valid", bus.ex_valid_o, 1);
    checkOutput("dz_hi",    bus.ex_hi_o, 32'd5);
    checkOutput("dz_lo",    bus.ex_lo_o, 32'hFFFFFFFF);

    // Flush at BUSY cycle 10 of a DIVU
    applyStimulus(8'h1B, 3'b101, 32'd1000, 32'd3, 5'd7, 1'b0);
    repeat (9) @(negedge clk);
    checkOutput("fl_busy", bus.ex_stall_o, 1);
    bus.ex_flush_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.ex_flush_i = 1'b0;
    checkOutput("fl_stall", bus.ex_stall_o, 0);
    n = 0;
    repeat (40) begin
      if (bus.ex_valid_o) n++;
      @(negedge clk);
    end
    checkOutput("fl_novalid", n, 0);
    checkOutput("fl_hi", bus.ex_hi_o, 32'd5);
    checkOutput("fl_lo", bus.ex_lo_o, 32'hFFFFFFFF);
    applyStimulus(8'h25, 3'b001, 32'h0000000F, 32'h000000F0, 5'd8, 1'b1);
    checkOutput("fl_or", bus.ex_wdata_o, 32'h000000FF);
    checkOutput("fl_or_valid", bus.ex_valid_o, 1);

    // Flush together with valid: instruction discarded
    bus.ex_flush_i = 1'b1;
    applyStimulus(8'h25, 3'b001, 32'h1, 32'h2, 5'd2, 1'b1);
    bus.ex_flush_i = 1'b0;
    checkOutput("flv_valid", bus.ex_valid_o, 0);
    checkOutput("flv_wdata", bus.ex_wdata_o, 32'h000000FF);

    // Async reset mid-MULTU, off-edge
    applyStimulus(8'h19, 3'b101, 32'd3, 32'd4, 5'd1, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("ar_stall", bus.ex_stall_o, 0);
    checkOutput("ar_wdata", bus.ex_wdata_o, 0);
    checkOutput("ar_hi",    bus.ex_hi_o, 0);
    checkOutput("ar_lo",    bus.ex_lo_o, 0);
    @(negedge clk);
    bus.ex_valid_i   = 1'b1;
    bus.ex_aluop_i   = 8'h21;
    bus.ex_alusel_i  = 3'b011;
    bus.ex_rdata_1_i = 32'd20;
    bus.ex_rdata_2_i = 32'd22;
    bus.ex_waddr_i   = 5'd12;
    bus.ex_we_i      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.ex_valid_i = 1'b0;
    checkOutput("ar_held_valid", bus.ex_valid_o, 1);
    checkOutput("ar_held_wdata", bus.ex_wdata_o, 32'd42);
    checkOutput("ar_held_waddr", bus.ex_waddr_o, 5'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
